// File: rtl/ofdm_s2p_pkg.sv
// Shared types for the OFDM TX serial-to-parallel path: arbiter FSM states
// and the converter word width used by both arbiter and converter.
package ofdm_s2p_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } s2p_state_e;

    localparam int S2P_WIDTH = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational requester arbiter: round-robin from a start pointer, or fixed
// priority (lowest index wins) when SER2PAR_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter
    import ofdm_s2p_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             any
);

`ifdef SER2PAR_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Scan high to low so the lowest asserted index is the final winner.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                gnt_id = ID_W'(i);
                any    = 1'b1;
            end
        end
    end
`else
    int idx;

    // Scan cyclic offsets from far to near so the index closest to ptr wins.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_id   = ID_W'(idx);
                any      = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/ser2par_arbiter.sv
// Shares one serial-to-parallel converter between N_REQ serial requesters.
// Define SER2PAR_ARB_FIXED_PRIO_EN for fixed-priority instead of round-robin.
module ser2par_arbiter
    import ofdm_s2p_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = S2P_WIDTH,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_din,
    input  logic [N_REQ-1:0] req_vld,
    output logic [N_REQ-1:0] req_rdy,
    output logic             s2p_din,
    output logic             s2p_din_vld,
    input  logic             s2p_in_rdy,
    input  logic             s2p_dout_vld,
    input  logic             s2p_dn_rdy,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_vld,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    s2p_state_e       state_q, state_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]  ptr_q;
    logic [N_REQ-1:0] arb_gnt_unused;
    logic [ID_W-1:0]  arb_id;
    logic             arb_any;
    logic             out_hs;

    assign out_hs = s2p_dout_vld & s2p_dn_rdy;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req    (req_vld),
        .ptr    (ptr_q),
        .gnt    (arb_gnt_unused),
        .gnt_id (arb_id),
        .any    (arb_any)
    );

`ifdef SER2PAR_ARB_FIXED_PRIO_EN
    assign ptr_q = '0;
`else
    logic [ID_W-1:0] ptr_d;

    // Next word starts searching just after the requester that was served.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == DRAIN && out_hs) begin
            ptr_d = (gnt_id_q == ID_W'(N_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`endif

    always_comb begin
        state_d     = state_q;
        gnt_id_d    = gnt_id_q;
        cnt_d       = cnt_q;
        s2p_din     = 1'b0;
        s2p_din_vld = 1'b0;
        req_rdy     = '0;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    gnt_id_d = arb_id;
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                s2p_din           = req_din[gnt_id_q];
                s2p_din_vld       = req_vld[gnt_id_q];
                req_rdy[gnt_id_q] = s2p_in_rdy;
                if (req_vld[gnt_id_q] && s2p_in_rdy) begin
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        cnt_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // gnt_id stays put so it labels the converter's output word.
                if (out_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_id_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_id_q <= gnt_id_d;
            cnt_q    <= cnt_d;
        end
    end

    assign gnt_id  = gnt_id_q;
    assign gnt_vld = (state_q != IDLE);
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_ser2par_arbiter.sv
// Randomized bench for ser2par_arbiter with a transaction-level reference model
// and a behavioural converter that assembles the forwarded words.
module tb_ser2par_arbiter;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int ID_W = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    req_din, req_vld, req_rdy;
  logic            s2p_din, s2p_din_vld, s2p_in_rdy;
  logic            s2p_dout_vld, s2p_dn_rdy;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_vld, busy;

  ser2par_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_din      (req_din),
    .req_vld      (req_vld),
    .req_rdy      (req_rdy),
    .s2p_din      (s2p_din),
    .s2p_din_vld  (s2p_din_vld),
    .s2p_in_rdy   (s2p_in_rdy),
    .s2p_dout_vld (s2p_dout_vld),
    .s2p_dn_rdy   (s2p_dn_rdy),
    .gnt_id       (gnt_id),
    .gnt_vld      (gnt_vld),
    .busy         (busy)
  );

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [ID_W+W-1:0] exp_q[$];
  int gnt_log[$];
  int rdy_cnt[N];
  int words_seen;
  logic [W-1:0]    last_word;
  logic [ID_W-1:0] last_word_id;

  // reference model: owner -1 means nobody holds the converter
  int m_owner, m_last, m_ptr, m_nbits;
  bit m_done;
  logic [W-1:0] m_word;

  // behavioural converter
  int c_nbits;
  bit c_full;
  logic [W-1:0] c_word;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_arb(input logic [N-1:0] v, input int ptr);
    int best = -1;
    int bd   = N + 1;
    int d;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
`ifdef SER2PAR_ARB_FIXED_PRIO_EN
        d = i;
`else
        d = (i - ptr + N) % N;
`endif
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = 0; m_ptr = 0; m_nbits = 0; m_done = 0; m_word = '0;
    c_nbits = 0; c_full = 0; c_word = '0;
    exp_q.delete();
  endtask

  // One clock: check outputs at negedge, advance model, drive converter after posedge.
  task automatic step();
    logic [N-1:0] e_rdy;
    logic e_vld, e_din;
    logic [ID_W+W-1:0] e;
    int w;
    @(negedge clk);
    e_rdy = '0; e_vld = 1'b0; e_din = 1'b0;
    if (m_owner >= 0 && !m_done) begin
      e_vld          = req_vld[m_owner];
      e_din          = req_din[m_owner];
      e_rdy[m_owner] = s2p_in_rdy;
    end
    check("req_rdy", 32'(req_rdy), 32'(e_rdy));
    check("din_vld", 32'(s2p_din_vld), 32'(e_vld));
    check("din", 32'(s2p_din), 32'(e_din));
    check("gnt_vld", 32'(gnt_vld), 32'(m_owner >= 0));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("gnt_id", 32'(gnt_id), 32'(m_last));
    for (int i = 0; i < N; i++) if (req_rdy[i] && req_vld[i]) rdy_cnt[i]++;

    if (s2p_dout_vld && s2p_dn_rdy) begin
      if (exp_q.size() == 0) begin
        check("word_q_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("word_id", 32'(gnt_id), 32'(e[W+:ID_W]));
        check("word_bits", 32'(c_word), 32'(e[W-1:0]));
      end
      words_seen++;
      last_word    = c_word;
      last_word_id = gnt_id;
    end

    // converter sees what the DUT forwards
    if (s2p_din_vld && s2p_in_rdy && !c_full) begin
      c_word[c_nbits] = s2p_din;
      c_nbits++;
      if (c_nbits == W) c_full = 1;
    end
    if (s2p_dout_vld && s2p_dn_rdy) begin
      c_full = 0; c_nbits = 0;
    end

    // reference model
    if (m_owner < 0) begin
      w = model_arb(req_vld, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_nbits = 0;
        gnt_log.push_back(w);
      end
    end else if (!m_done) begin
      if (req_vld[m_owner] && s2p_in_rdy) begin
        m_word[m_nbits] = req_din[m_owner];
        m_nbits++;
        if (m_nbits == W) begin
          m_done = 1;
          exp_q.push_back({ID_W'(m_owner), m_word});
        end
      end
    end else if (s2p_dout_vld && s2p_dn_rdy) begin
      m_ptr = (m_owner + 1) % N; m_owner = -1; m_done = 0;
    end

    @(posedge clk);
    #1;
    s2p_dout_vld = c_full;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_vld = '1; req_din = '1; s2p_in_rdy = 1'b1; s2p_dn_rdy = 1'b1; s2p_dout_vld = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_gnt_id", 32'(gnt_id), 32'd0);
    check("rst_gnt_vld", 32'(gnt_vld), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_rdy", 32'(req_rdy), 32'd0);
    check("rst_din_vld", 32'(s2p_din_vld), 32'd0);
    check("rst_din", 32'(s2p_din), 32'd0);
    @(posedge clk);
    @(negedge clk);
    req_vld = '0;
    rst_n   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_random(input int pv, input int pin, input int pdn);
    for (int i = 0; i < N; i++) begin
      req_vld[i] = ($urandom_range(99) < pv);
      req_din[i] = 1'($urandom_range(1));
    end
    s2p_in_rdy = ($urandom_range(99) < pin);
    s2p_dn_rdy = ($urandom_range(99) < pdn);
  endtask

  initial begin
    logic [W-1:0] pat;
    int exp_order[5];
    int base3;
    int guard;
    words_seen = 0;
    for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
    do_reset();

    // single requester 2, pattern 1,0,1,1,0,0,1,0 (first bit in LSB)
    pat = 8'b0100_1101;
    s2p_in_rdy = 1'b1; s2p_dn_rdy = 1'b1;
    for (int c = 0; c < 30; c++) begin
      req_vld = (rdy_cnt[2] < 8) ? 4'b0100 : 4'b0000;
      req_din = '0;
      req_din[2] = (rdy_cnt[2] < 8) ? pat[rdy_cnt[2]] : 1'b0;
      step();
    end
    check("p2_rdy_pulses", 32'(rdy_cnt[2]), 32'd8);
    check("p2_words", 32'(words_seen), 32'd1);
    check("p2_word", 32'(last_word), 32'h4D);
    check("p2_word_id", 32'(last_word_id), 32'd2);
    check("p2_idle", 32'(busy), 32'd0);

    // all requesters valid, converter always ready
    do_reset();
    gnt_log.delete();
`ifdef SER2PAR_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    for (int c = 0; c < 60; c++) begin
      req_vld = '1;
      for (int i = 0; i < N; i++) req_din[i] = 1'($urandom_range(1));
      s2p_in_rdy = 1'b1; s2p_dn_rdy = 1'b1;
      step();
    end
    if (gnt_log.size() < 5) check("order_len", 32'(gnt_log.size()), 32'd5);
    else for (int k = 0; k < 5; k++) check($sformatf("order_%0d", k), 32'(gnt_log[k]), 32'(exp_order[k]));

    // randomized traffic with stalls on both converter sides
    for (int ph = 0; ph < 6; ph++) begin
      int pv  = $urandom_range(20, 95);
      int pin = $urandom_range(30, 100);
      int pdn = $urandom_range(10, 100);
      for (int c = 0; c < 500; c++) begin
        drive_random(pv, pin, pdn);
        step();
      end
    end

    // requester 3 reset after 5 bits, then everyone requests
    do_reset();
    base3 = rdy_cnt[3];
    guard = 0;
    while (rdy_cnt[3] - base3 < 5 && guard < 40) begin
      req_vld = 4'b1000;
      req_din = 4'($urandom_range(15));
      s2p_in_rdy = 1'b1; s2p_dn_rdy = 1'b1;
      step();
      guard++;
    end
    check("mid_word_bits", 32'(rdy_cnt[3] - base3), 32'd5);
    check("mid_word_id", 32'(gnt_id), 32'd3);
    do_reset();
    gnt_log.delete();
    for (int c = 0; c < 3; c++) begin
      req_vld = '1;
      step();
    end
    if (gnt_log.size() == 0) check("post_rst_gnt", 32'hFFFF, 32'd0);
    else check("post_rst_gnt", 32'(gnt_log[0]), 32'd0);

    check("words_seen_nonzero", 32'(words_seen > 10), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
